// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side framer:
// FSM state encoding and default datapath widths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_A  = 3'd1,
      GET_B  = 3'd2,
      GET_OP = 3'd3,
      HOLD   = 3'd4
   } state_t;

   // default widths: received byte, ALU operand, opcode
   localparam int DEF_DBIT    = 8;
   localparam int DEF_NB_DATA = 16;
   localparam int DEF_NB_OP   = 6;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer for the receive framer.
// Ports: i_clk, i_rst (async, active-low), i_enable (count while in a
// frame), i_clear (byte strobe), o_expired (one-cycle limit pulse).
module rx_timeout_timer #(
   parameter int TIMEOUT = 50000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expired
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LIMIT =
      TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [TW-1:0] tmr;

   // a strobe on the limit cycle wins over expiry
   assign o_expired = (TIMEOUT > 0) && i_enable &&
                      !i_clear && (tmr == LIMIT);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         tmr <= '0;
      end else if (!i_enable || i_clear ||
                   o_expired || (TIMEOUT == 0)) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 1'b1;
      end
   end

endmodule

// File: rtl/interfaz_rx_frame.sv
// Receive framer: collects operand A, operand B (LSB byte first) and an
// opcode byte, then presents the frame to the ALU via valid/ready.
// Ports: i_clk, i_rst (async, active-low), i_data/i_done_data (byte
// stream), i_ready (ALU accept), o_a/o_b/o_op (frame), o_valid,
// o_timeout (partial frame dropped), o_overrun (byte dropped in HOLD).
module interfaz_rx_frame
   import uart_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int NB_DATA = DEF_NB_DATA,
   parameter int NB_OP   = DEF_NB_OP,
   parameter int TIMEOUT = 50000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [DBIT-1:0]    i_data,
   input  logic               i_done_data,
   input  logic               i_ready,
   output logic [NB_DATA-1:0] o_a,
   output logic [NB_DATA-1:0] o_b,
   output logic [NB_OP-1:0]   o_op,
   output logic               o_valid,
   output logic               o_timeout,
   output logic               o_overrun
);

   localparam int BPO = NB_DATA / DBIT;
   localparam int CW  = $clog2(BPO) + 1;
   localparam logic [CW-1:0] LAST = CW'(BPO - 1);

   state_t state, state_n;

   logic [CW-1:0]      cnt, cnt_n;
   logic [NB_DATA-1:0] sh_a, sh_b;
   logic               take_a, wr_b, ld_out;
   logic               to_n, ovr_n, tmr_en, expired;

   rx_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_enable  (tmr_en),
      .i_clear   (i_done_data),
      .o_expired (expired)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      take_a  = 1'b0;
      wr_b    = 1'b0;
      ld_out  = 1'b0;
      to_n    = 1'b0;
      ovr_n   = 1'b0;
      tmr_en  = 1'b0;

      unique case (state)
         IDLE: begin
            take_a = i_done_data;
         end
         GET_A: begin
            tmr_en = 1'b1;
            if (i_done_data) begin
               take_a = 1'b1;
            end else if (expired) begin
               state_n = IDLE;
               cnt_n   = '0;
               to_n    = 1'b1;
            end
         end
         GET_B: begin
            tmr_en = 1'b1;
            if (i_done_data) begin
               wr_b = 1'b1;
               if (cnt == LAST) begin
                  state_n = GET_OP;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else if (expired) begin
               state_n = IDLE;
               cnt_n   = '0;
               to_n    = 1'b1;
            end
         end
         GET_OP: begin
            tmr_en = 1'b1;
            if (i_done_data) begin
               ld_out  = 1'b1;
               state_n = HOLD;
            end else if (expired) begin
               state_n = IDLE;
               cnt_n   = '0;
               to_n    = 1'b1;
            end
         end
         HOLD: begin
            if (i_ready) begin
               // handshake done; a byte in the same cycle
               // starts the next frame
               state_n = IDLE;
               take_a  = i_done_data;
            end else if (i_done_data) begin
               ovr_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      // cnt is 0 in IDLE and HOLD, so a first byte hits lane 0
      if (take_a) begin
         if (cnt == LAST) begin
            state_n = GET_B;
            cnt_n   = '0;
         end else begin
            state_n = GET_A;
            cnt_n   = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sh_a      <= '0;
         sh_b      <= '0;
         o_a       <= '0;
         o_b       <= '0;
         o_op      <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         o_valid   <= (state_n == HOLD);
         o_timeout <= to_n;
         o_overrun <= ovr_n;
         for (int k = 0; k < BPO; k++) begin
            if (take_a && cnt == CW'(k))
               sh_a[k*DBIT +: DBIT] <= i_data;
            if (wr_b && cnt == CW'(k))
               sh_b[k*DBIT +: DBIT] <= i_data;
         end
         // frame outputs move together, only on completion
         if (ld_out) begin
            o_a  <= sh_a;
            o_b  <= sh_b;
            o_op <= i_data[NB_OP-1:0];
         end
      end
   end

endmodule
